// File: rtl/cache_fill_fsm_pkg.sv
// cache_fill_fsm_pkg: state encodings and block-geometry helpers shared
// by the fill engine and the cache tag/data arrays.
package cache_fill_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        DONE = 2'b10
    } fill_state_e;

    function automatic int bytes_per_word(input int dwidth);
        return dwidth / 8;
    endfunction

    function automatic int block_off(input int dwidth, input int words);
        return $clog2(words * (dwidth / 8));
    endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// cache_fill_if: miss request, memory read port and cache array write
// port of one fill engine; master is the engine, slave the environment.
interface cache_fill_if #(
    parameter int DWIDTH          = 16,
    parameter int AWIDTH          = 16,
    parameter int WORDS_PER_BLOCK = 8
);
    localparam int IW = $clog2(WORDS_PER_BLOCK);

    logic              miss_detected;
    logic [AWIDTH-1:0] miss_address;
    logic              fsm_busy;
    logic              mem_read;
    logic [AWIDTH-1:0] memory_address;
    logic              memory_data_valid;
    logic [DWIDTH-1:0] memory_data;
    logic              write_data_array;
    logic [IW-1:0]     cache_word_index;
    logic [DWIDTH-1:0] cache_data;
    logic              write_tag_array;
    logic              fill_done;

    modport master (
        input  miss_detected,
        input  miss_address,
        input  memory_data_valid,
        input  memory_data,
        output fsm_busy,
        output mem_read,
        output memory_address,
        output write_data_array,
        output cache_word_index,
        output cache_data,
        output write_tag_array,
        output fill_done
    );

    modport slave (
        output miss_detected,
        output miss_address,
        output memory_data_valid,
        output memory_data,
        input  fsm_busy,
        input  mem_read,
        input  memory_address,
        input  write_data_array,
        input  cache_word_index,
        input  cache_data,
        input  write_tag_array,
        input  fill_done
    );

endinterface

// File: rtl/cache_fill_fsm_block_counter.sv
// block_counter: saturating up-counter with synchronous clear and a
// terminal-count flag, used for both read issue and word receive.
module block_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tc_o  = (cnt_q == MAX_V);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: on a miss, stalls the pipeline, streams one aligned
// block from pipelined memory into the data array, then writes the tag.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int DWIDTH          = 16,
    parameter int AWIDTH          = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input logic          clk,
    input logic          rst,
    cache_fill_if.master bus
);
    localparam int BYTES = bytes_per_word(DWIDTH);
    localparam int OFF   = block_off(DWIDTH, WORDS_PER_BLOCK);
    localparam int IW    = $clog2(WORDS_PER_BLOCK);
    localparam int CW    = IW + 1;

    localparam logic [AWIDTH-1:0] BASE_MASK = {AWIDTH{1'b1}} << OFF;
    localparam logic [AWIDTH-1:0] BYTES_A   = AWIDTH'(BYTES);

    fill_state_e       state_q;
    fill_state_e       state_d;
    logic [AWIDTH-1:0] base_q;
    logic [AWIDTH-1:0] base_d;
    logic              rd_q;
    logic              rd_d;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] addr_d;

    logic              fill_st;
    logic              done_st;
    logic              accept;
    logic [CW-1:0]     issue_cnt;
    logic              issue_tc;
    logic [IW-1:0]     rcv_cnt;
    logic              rcv_last;

    assign fill_st = (state_q == FILL);
    assign done_st = (state_q == DONE);
    assign accept  = fill_st && bus.memory_data_valid;

    // issue_cnt counts reads already loaded into the output register,
    // so it runs one ahead of the read currently on the bus
    block_counter #(
        .WIDTH (CW),
        .MAX   (WORDS_PER_BLOCK)
    ) u_issue (
        .clk   (clk),
        .rst   (rst),
        .clr_i (done_st),
        .en_i  (rd_d),
        .cnt_o (issue_cnt),
        .tc_o  (issue_tc)
    );

    block_counter #(
        .WIDTH (IW),
        .MAX   (WORDS_PER_BLOCK - 1)
    ) u_rcv (
        .clk   (clk),
        .rst   (rst),
        .clr_i (done_st),
        .en_i  (accept),
        .cnt_o (rcv_cnt),
        .tc_o  (rcv_last)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        unique case (state_q)
            IDLE: begin
                if (bus.miss_detected) begin
                    state_d = FILL;
                    base_d  = bus.miss_address & BASE_MASK;
                end
            end
            FILL: begin
                if (accept && rcv_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rd_d   = (state_d == FILL) && !issue_tc;
        addr_d = addr_q;
        if (rd_d) begin
            addr_d = base_d + AWIDTH'(issue_cnt) * BYTES_A;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.fsm_busy         = fill_st;
    assign bus.mem_read         = rd_q;
    assign bus.memory_address   = addr_q;
    assign bus.write_data_array = accept;
    assign bus.cache_word_index = rcv_cnt;
    assign bus.cache_data       = bus.memory_data;
    assign bus.write_tag_array  = accept && rcv_last;
    assign bus.fill_done        = done_st;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: scoreboard bench; stimulus pushes expected reads,
// writes and busy lengths, a negedge monitor pops and compares them.
module tb_cache_fill_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_fill_if #(.DWIDTH(16), .AWIDTH(16), .WORDS_PER_BLOCK(8)) if8 ();
    cache_fill_if #(.DWIDTH(16), .AWIDTH(16), .WORDS_PER_BLOCK(4)) if4 ();

    cache_fill_fsm #(.DWIDTH(16), .AWIDTH(16), .WORDS_PER_BLOCK(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    cache_fill_fsm #(.DWIDTH(16), .AWIDTH(16), .WORDS_PER_BLOCK(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    logic        sel;
    logic        miss;
    logic        stray;
    logic [15:0] maddr;
    logic        mv;
    logic [15:0] md;

    assign if8.miss_detected     = miss & !sel;
    assign if8.miss_address      = maddr;
    assign if8.memory_data_valid = (mv | stray) & !sel;
    assign if8.memory_data       = md;
    assign if4.miss_detected     = miss & sel;
    assign if4.miss_address      = maddr;
    assign if4.memory_data_valid = (mv | stray) & sel;
    assign if4.memory_data       = md;

    logic        m_read, m_wr, m_tag, m_done, m_busy;
    logic [15:0] m_addr, m_data;
    logic [5:0]  m_idx;

    assign m_read = sel ? if4.mem_read : if8.mem_read;
    assign m_addr = sel ? if4.memory_address : if8.memory_address;
    assign m_wr   = sel ? if4.write_data_array : if8.write_data_array;
    assign m_idx  = sel ? 6'(if4.cache_word_index) : 6'(if8.cache_word_index);
    assign m_data = sel ? if4.cache_data : if8.cache_data;
    assign m_tag  = sel ? if4.write_tag_array : if8.write_tag_array;
    assign m_done = sel ? if4.fill_done : if8.fill_done;
    assign m_busy = sel ? if4.fsm_busy : if8.fsm_busy;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    task automatic unexp(input string nm);
        checks++;
        $display("FAIL %s: got unexpected event, required none", nm);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        int          due;
    } req_t;

    req_t pend[$];
    int   lat = 4;

    // pipelined memory: a read seen in cycle c returns addr^5A5A in c+lat
    initial begin
        mv = 1'b0;
        md = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            mv = 1'b0;
            if (rst) begin
                pend.delete();
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    mv = 1'b1;
                    md = pend[0].a ^ 16'h5A5A;
                    void'(pend.pop_front());
                end
                if (m_read) pend.push_back('{m_addr, cyc + lat});
            end
        end
    end

    typedef struct {
        logic [5:0]  idx;
        logic [15:0] d;
        logic        tag;
    } wr_t;

    logic [15:0] exp_rd[$];
    wr_t         exp_wr[$];
    int          exp_busy[$];
    int          exp_done = 0;
    int          busy_run = 0;
    int          wr_seen = 0;
    int          last_tag_cyc = -10;

    always @(negedge clk) begin
        wr_t w;
        if (m_read) begin
            if (exp_rd.size() == 0) unexp("read");
            else chk("rd_addr", 32'(m_addr), 32'(exp_rd.pop_front()));
        end
        if (m_wr) begin
            wr_seen++;
            if (exp_wr.size() == 0) begin
                unexp("write");
            end else begin
                w = exp_wr.pop_front();
                chk("wr_idx", 32'(m_idx), 32'(w.idx));
                chk("wr_data", 32'(m_data), 32'(w.d));
                chk("wr_tag", 32'(m_tag), 32'(w.tag));
            end
            if (m_tag) last_tag_cyc = cyc;
        end else if (m_tag) begin
            unexp("tag_without_write");
        end
        if (m_done) begin
            if (exp_done == 0) begin
                unexp("fill_done");
            end else begin
                exp_done--;
                chk("done_after_tag", 32'(cyc), 32'(last_tag_cyc + 1));
                chk("done_busy", 32'(m_busy), 32'd0);
            end
        end
        if (m_busy) begin
            busy_run++;
        end else if (busy_run > 0) begin
            if (exp_busy.size() == 0) unexp("busy");
            else chk("busy_len", 32'(busy_run), 32'(exp_busy.pop_front()));
            busy_run = 0;
        end
    end

    task automatic push_fill(input logic [15:0] base, input int w, input int nrd,
                             input int nwr, input int busy, input bit full);
        for (int i = 0; i < nrd; i++) exp_rd.push_back(base + 16'(i * 2));
        for (int i = 0; i < nwr; i++)
            exp_wr.push_back('{6'(i), (base + 16'(i * 2)) ^ 16'h5A5A, full && (i == w - 1)});
        exp_busy.push_back(busy);
        if (full) exp_done++;
    endtask

    task automatic fire(input logic [15:0] a);
        @(negedge clk);
        maddr = a;
        miss  = 1'b1;
        @(negedge clk);
        miss  = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((exp_done != 0 || m_busy || exp_rd.size() != 0 || exp_wr.size() != 0)
               && n < maxc) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= maxc) begin
            checks++;
            $display("FAIL fill_timeout: waited %0d cycles, required fill to finish", n);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_busy"}, 32'(m_busy), 32'd0);
        chk({nm, "_read"}, 32'(m_read), 32'd0);
        chk({nm, "_wr"}, 32'(m_wr), 32'd0);
        chk({nm, "_tag"}, 32'(m_tag), 32'd0);
        chk({nm, "_done"}, 32'(m_done), 32'd0);
        chk({nm, "_addr"}, 32'(m_addr), 32'd0);
    endtask

    initial begin
        int wr0;
        int n;
        sel   = 1'b0;
        miss  = 1'b0;
        stray = 1'b0;
        maddr = 16'h0;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst = 1'b0;

        // latency 4, unaligned miss
        lat = 4;
        push_fill(16'h1230, 8, 8, 8, 12, 1'b1);
        fire(16'h1237);
        wait_idle(80);

        // latency 1, issue and accept overlap
        lat = 1;
        push_fill(16'h1230, 8, 8, 8, 9, 1'b1);
        fire(16'h123F);
        wait_idle(80);

        // stray valids in IDLE, re-miss during FILL
        lat = 2;
        wr0 = wr_seen;
        @(negedge clk);
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        #1;
        chk("stray_no_write", 32'(wr_seen), 32'(wr0));
        chk("stray_idle", 32'(m_busy), 32'd0);
        push_fill(16'h1230, 8, 8, 8, 10, 1'b1);
        fire(16'h1237);
        maddr = 16'h4000;
        miss  = 1'b1;
        @(negedge clk);
        miss  = 1'b0;
        @(negedge clk);
        miss  = 1'b1;
        @(negedge clk);
        miss  = 1'b0;
        wait_idle(80);

        // async reset after three accepted words
        lat = 4;
        wr0 = wr_seen;
        push_fill(16'h1230, 8, 7, 3, 7, 1'b0);
        fire(16'h1237);
        n = 0;
        while (wr_seen < wr0 + 3 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            $display("FAIL abort_wait: got %0d writes, required 3", wr_seen - wr0);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_quiet("abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_rd_left", 32'(exp_rd.size()), 32'd0);
        chk("abort_wr_left", 32'(exp_wr.size()), 32'd0);
        chk("abort_busy_left", 32'(exp_busy.size()), 32'd0);
        push_fill(16'h1230, 8, 8, 8, 12, 1'b1);
        fire(16'h1231);
        wait_idle(80);

        // 4-word blocks at the top of the address space
        sel = 1'b1;
        lat = 2;
        push_fill(16'hFFF8, 4, 4, 4, 6, 1'b1);
        fire(16'hFFFA);
        wait_idle(80);
        sel = 1'b0;

        // miss held high: back-to-back fills
        lat = 1;
        push_fill(16'h2460, 8, 8, 8, 9, 1'b1);
        push_fill(16'h2460, 8, 8, 8, 9, 1'b1);
        @(negedge clk);
        maddr = 16'h2468;
        miss  = 1'b1;
        n = 0;
        while (exp_done > 1 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 60) begin
            checks++;
            $display("FAIL hold_first: got no fill_done, required one");
        end
        @(negedge clk);
        #1;
        chk("hold_idle_gap", 32'(m_busy), 32'd0);
        @(negedge clk);
        #1;
        chk("hold_refill", 32'(m_busy), 32'd1);
        n = 0;
        while (exp_done > 0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        miss = 1'b0;
        if (n >= 60) begin
            checks++;
            $display("FAIL hold_second: got no fill_done, required one");
        end
        repeat (4) @(negedge clk);
        #1;
        chk("hold_stopped", 32'(m_busy), 32'd0);

        chk("left_rd", 32'(exp_rd.size()), 32'd0);
        chk("left_wr", 32'(exp_wr.size()), 32'd0);
        chk("left_busy", 32'(exp_busy.size()), 32'd0);
        chk("left_done", 32'(exp_done), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Parametrised miss-handling engine for the next-generation WISC-FA24 core, which moves from single-cycle memory to a cache backed by pipelined multi-cycle memory.
- On a cache miss it stalls the pipeline and issues one read per cycle for every word of the aligned block.
- It streams each returned word into the data array and writes the tag on the last word.
- One instance serves the I-cache and one serves the D-cache. An arbiter upstream grants memory to a single instance at a time.

Parameters:
DWIDTH, 16, word width in bits; must be a multiple of 8.
AWIDTH, 16, byte address width.
WORDS_PER_BLOCK, 8, words per cache block; power of two, 2..64.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
miss_detected  in  1  level from tag compare; sampled only in IDLE
miss_address  in  AWIDTH  byte address of the missing access
fsm_busy  out  1  pipeline stall; high while state is FILL
mem_read  out  1  memory read strobe, one word per cycle
memory_address  out  AWIDTH  byte address of the current read
memory_data_valid  in  1  returned-word strobe from memory; in-order, latency of 1 or more cycles
memory_data  in  DWIDTH  returned word
write_data_array  out  1  data-array write enable
cache_word_index  out  log2(WORDS_PER_BLOCK)  word slot for write_data_array
cache_data  out  DWIDTH  word to write; combinational copy of memory_data
write_tag_array  out  1  tag write; asserted with the last data write
fill_done  out  1  one-cycle pulse, the cycle after the last word is written

Behaviour:
- The clock and reset are fixed: one clock; reset is asynchronous and active-high.
- Derived constants:
  - BYTES = DWIDTH/8
  - OFF = log2(WORDS_PER_BLOCK*BYTES)
  - base = miss_address with its low OFF bits cleared, latched on entry to FILL.
- Reset: state IDLE, both counters 0, and every registered output 0. fsm_busy, mem_read, write_data_array, write_tag_array and fill_done are 0 during reset.
- States:
  - IDLE -> FILL when miss_detected=1. There is 1 cycle of latency: fsm_busy goes high the cycle after the miss is seen.
  - FILL -> DONE on the cycle the last word is accepted.
  - DONE -> IDLE unconditionally after 1 cycle. fill_done=1 and fsm_busy=0 in DONE.
- Issue counter (issue_cnt):
  - In FILL, mem_read=1 while issue_cnt < WORDS_PER_BLOCK.
  - memory_address = base + issue_cnt*BYTES, computed modulo 2^AWIDTH.
  - issue_cnt increments each issuing cycle and saturates at WORDS_PER_BLOCK. The counter is log2(WORDS_PER_BLOCK)+1 bits wide.
- Receive counter (rcv_cnt):
  - In FILL, write_data_array = memory_data_valid, and cache_word_index = rcv_cnt.
  - rcv_cnt increments on each valid.
  - Acceptance and issue may happen in the same cycle.
- Last word: when memory_data_valid=1 and rcv_cnt=WORDS_PER_BLOCK-1, write_data_array and write_tag_array are both 1 in the same cycle, and the state moves to DONE.
- The block writes no more than WORDS_PER_BLOCK words per fill. memory_data_valid is ignored in IDLE and DONE, with no write and no counter change.
- miss_detected is ignored in FILL and DONE. A miss held high through DONE starts a new fill from IDLE the cycle after.
- Reset asserted mid-fill aborts immediately: counters clear, no tag write, no fill_done.
- mem_read and memory_address are registered outputs. write_data_array, write_tag_array and cache_data are combinational from memory_data_valid and state.

Decomposition:
- Shared include file wisc_defs.vh holds:
  - state encodings: IDLE=2'b00, FILL=2'b01, DONE=2'b10
  - the BYTES and OFF derivation macros, reused by the cache tag/data arrays.
- One sub-module: block_counter, a parametrised-width up-counter with clear, enable and terminal-count outputs. It is instantiated twice, once for issue and once for receive.

Test Plan:
1. Default parameters; miss_address=0x1237; memory model with latency 4.
   - -> memory_address sequence is 0x1230, 0x1232, …, 0x123E on 8 consecutive mem_read cycles.
   - -> 8 writes with index 0..7; write_tag_array on index 7; fill_done pulses once.
   - -> fsm_busy is high for exactly 8+4 cycles.
2. Latency 1 model with back-to-back valids.
   - -> issue and accept overlap; fill completes 9 cycles after FILL entry.
   - -> fsm_busy drops the cycle after the last write.
3. Toggle miss_detected and pulse memory_data_valid during IDLE and FILL.
   - -> stray valids in IDLE cause no write; a second miss during FILL does not restart; base stays 0x1230.
4. Assert rst asynchronously after 3 words have been accepted.
   - -> outputs go to 0 immediately; no write_tag_array and no fill_done.
   - -> the next miss refills from index 0.
5. WORDS_PER_BLOCK=4 with miss_address=0xFFFA.
   - -> base is 0xFFF8; addresses are 0xFFF8 through 0xFFFE with no wrap; tag write on index 3.
6. miss_detected held high continuously.
   - -> after DONE, a second fill starts in the following cycle.
   - -> fill_done occurs exactly once per fill.
